// File: rtl/act_buf_pkg.sv
// Shared types for the activation-buffer responder: host command opcodes and controller states.
package act_buf_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_DUMP = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN_GO = 3'd2,
        S_RUN    = 3'd3,
        S_DUMP   = 3'd4
    } state_t;

endpackage

// File: rtl/act_buf_mem.sv
// Feature-map storage: DEPTH x DATA_W words, async read port, write on rising clk.
// Contents are not reset; callers gate out-of-range addresses before they get here.
module act_buf_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/act_buf_server.sv
// Activation-buffer responder: host LOAD/RUN/DUMP sequencing over one array; runner reads same-cycle.
// Dump output is registered (first word 1 cycle after accept) and holds while dp_ready is low.
module act_buf_server
    import act_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [DATA_W-1:0] dp_data,
    output logic              run_start,
    input  logic              run_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;

    logic [ADDR_W-1:0] host_addr;
    logic              host_ok;
    logic              rd_ok;
    logic              wr_ok;

    logic [ADDR_W-1:0] mem_raddr;
    logic              raddr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] fetch_dat;

    // Host stream address wraps in ADDR_W bits before the range check.
    assign host_addr = base_q + ADDR_W'(cnt_q);
    assign host_ok   = host_addr < DEPTH_A;
    assign rd_ok     = rd_addr < DEPTH_A;
    assign wr_ok     = wr_addr < DEPTH_A;

    // In IDLE the read port looks at cmd_base so the first dump word is ready at accept.
    always_comb begin
        mem_raddr = cmd_base;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_we    = 1'b0;
        case (state_q)
            S_LOAD: begin
                mem_waddr = host_addr;
                mem_wdata = ld_data;
                mem_we    = ld_valid && host_ok;
            end
            S_RUN: begin
                mem_raddr = rd_addr;
                mem_we    = wr_en && wr_ok;
            end
            S_DUMP: begin
                mem_raddr = host_addr;
            end
            default: ;
        endcase
    end

    assign raddr_ok  = mem_raddr < DEPTH_A;
    assign fetch_dat = raddr_ok ? mem_rdata : '0;
    assign rd_data   = (state_q == S_RUN && rd_en && raddr_ok) ? mem_rdata : '0;

    assign cmd_ready = (state_q == S_IDLE);
    assign ld_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);

    act_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr[AW-1:0]),
        .wdata (mem_wdata),
        .raddr (mem_raddr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            dp_valid  <= 1'b0;
            dp_data   <= '0;
            run_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            run_start <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        base_q <= cmd_base;
                        len_q  <= cmd_len;
                        cnt_q  <= '0;
                        case (cmd_op_t'(cmd_op))
                            CMD_LOAD: begin
                                if (cmd_len != '0) begin
                                    state_q <= S_LOAD;
                                end
                            end
                            CMD_RUN: begin
                                state_q   <= S_RUN_GO;
                                run_start <= 1'b1;
                            end
                            CMD_DUMP: begin
                                if (cmd_len != '0) begin
                                    state_q  <= S_DUMP;
                                    dp_valid <= 1'b1;
                                    dp_data  <= fetch_dat;
                                    cnt_q    <= LEN_W'(1);
                                    if (!raddr_ok) begin
                                        err <= 1'b1;
                                    end
                                end
                            end
                            default: begin
                                err <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        if (!host_ok) begin
                            err <= 1'b1;
                        end
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RUN_GO: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if ((rd_en && !rd_ok) || (wr_en && !wr_ok)) begin
                        err <= 1'b1;
                    end
                    if (run_done) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DUMP: begin
                    // cnt_q counts words already placed in dp_data.
                    if (dp_valid && dp_ready) begin
                        if (cnt_q == len_q) begin
                            dp_valid <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            dp_data <= fetch_dat;
                            cnt_q   <= cnt_q + LEN_W'(1);
                            if (!raddr_ok) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_act_buf_server.sv
// Bench for act_buf_server: directed scenarios plus randomized load/run/dump against a word-map model.
module tb_act_buf_server;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4096;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              dp_valid;
    logic              dp_ready;
    logic [DATA_W-1:0] dp_data;
    logic              run_start;
    logic              run_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: known contents of the array, keyed by word address.
    logic [7:0] model [int];

    always #5 clk = ~clk;

    act_buf_server #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .dp_valid  (dp_valid),
        .dp_ready  (dp_ready),
        .dp_data   (dp_data),
        .run_start (run_start),
        .run_done  (run_done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] base, input int len);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [7:0] d);
        if (a < 32'(DEPTH)) model[int'(a)] = d;
    endtask

    task automatic do_load(input logic [31:0] base, input logic [7:0] words[$], input bit gaps);
        send_cmd(2'd0, base, words.size());
        for (int i = 0; i < words.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) tick();
            end
            ld_valid = 1'b1;
            ld_data  = words[i];
            tick();
            ld_valid = 1'b0;
            model_write(base + 32'(i), words[i]);
        end
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1,1 then ready, 2: random ready.
    task automatic do_dump(input logic [31:0] base, input int len, input int mode,
                           output logic [7:0] got[$], output int stall_err,
                           output int first_lat, output int cycles);
        bit         pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bit         prev_stall = 1'b0;
        logic [7:0] prev_dat = '0;
        got = {};
        stall_err = 0;
        first_lat = -1;
        cycles = 0;
        send_cmd(2'd2, base, len);
        while (got.size() < len && cycles < 500) begin
            case (mode)
                0:       dp_ready = 1'b1;
                1:       dp_ready = (cycles < 5) ? pat[cycles] : 1'b1;
                default: dp_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (prev_stall && (dp_valid !== 1'b1 || dp_data !== prev_dat)) stall_err++;
            if (dp_valid === 1'b1 && first_lat < 0) first_lat = cycles;
            if (dp_valid === 1'b1 && dp_ready) got.push_back(dp_data);
            prev_stall = (dp_valid === 1'b1) && !dp_ready;
            prev_dat   = dp_data;
            @(posedge clk);
            #1;
            cycles++;
        end
        dp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0;
        ld_valid = 0; ld_data = 0; dp_ready = 0; run_done = 0;
        rd_en = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, cmd_ready, ld_ready, dp_valid, run_start, err} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy,cmd_rdy,ld_rdy,dp_vld,run_start,err=%b want 010000",
                     {busy, cmd_ready, ld_ready, dp_valid, run_start, err});
        end
        n_checks++;
        if (dp_data !== 8'h00 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got dp_data=%h rd_data=%h want 00 00", dp_data, rd_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_dump();
        logic [7:0] w[$] = '{8'h01, 8'hFE, 8'h03, 8'hFC};
        logic [7:0] got[$];
        int se, fl, cyc;
        do_load(32'd0, w, 1'b0);
        do_dump(32'd0, 4, 0, got, se, fl, cyc);
        n_checks++;
        if (got != w) begin
            n_fail++;
            $display("FAIL load_dump_data: got %p want %p", got, w);
        end
        n_checks++;
        if (fl != 0 || cyc != 4) begin
            n_fail++;
            $display("FAIL load_dump_timing: got first_lat=%0d cycles=%0d want 0 4", fl, cyc);
        end
        @(negedge clk);
        n_checks++;
        if (dp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_end: got dp_valid=%b busy=%b want 0 0", dp_valid, busy);
        end
        tick();
    endtask

    task automatic test_dump_stall();
        logic [7:0] got[$];
        logic [7:0] exp[$] = '{8'h01, 8'hFE, 8'h03};
        int se, fl, cyc;
        do_dump(32'd0, 3, 1, got, se, fl, cyc);
        n_checks++;
        if (got != exp || se != 0 || cyc != 5) begin
            n_fail++;
            $display("FAIL dump_stall: got %p stall_err=%0d cycles=%0d want %p 0 5", got, se, cyc, exp);
        end
    endtask

    task automatic test_run();
        int pulses = 0;
        send_cmd(2'd1, 32'd0, 0);
        @(negedge clk);
        if (run_start === 1'b1) pulses++;
        tick();
        rd_en = 1'b1;
        rd_addr = 32'd2;
        @(negedge clk);
        if (run_start === 1'b1) pulses++;
        n_checks++;
        if (rd_data !== 8'h03) begin
            n_fail++;
            $display("FAIL run_read: got %h want 03", rd_data);
        end
        tick();
        rd_en = 1'b0;
        wr_en = 1'b1; wr_addr = 32'd10; wr_data = 8'h07;
        @(negedge clk);
        if (run_start === 1'b1) pulses++;
        tick();
        model[10] = 8'h07;
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 32'd10;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h07) begin
            n_fail++;
            $display("FAIL run_write_read: got %h want 07", rd_data);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL run_start_pulses: got %0d want 1", pulses);
        end
        tick();
        rd_en = 1'b0;
        run_done = 1'b1;
        tick();
        run_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_done_idle: got busy=%b want 0", busy);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        logic [7:0] got[$];
        logic [7:0] exp[$] = '{8'h0B, 8'h5A};
        int se, fl, cyc;
        send_cmd(2'd1, 32'd0, 0);
        tick();
        wr_en = 1'b1; wr_addr = 32'd5; wr_data = 8'h09;
        tick();
        rd_en = 1'b1; rd_addr = 32'd5; wr_data = 8'h0B;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h09) begin
            n_fail++;
            $display("FAIL same_cycle_old: got %h want 09", rd_data);
        end
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h0B) begin
            n_fail++;
            $display("FAIL same_cycle_new: got %h want 0b", rd_data);
        end
        tick();
        rd_en = 1'b0;
        // Write in the run_done cycle must still land.
        run_done = 1'b1; wr_en = 1'b1; wr_addr = 32'd6; wr_data = 8'h5A;
        tick();
        run_done = 1'b0; wr_en = 1'b0;
        model[5] = 8'h0B;
        model[6] = 8'h5A;
        do_dump(32'd5, 2, 0, got, se, fl, cyc);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL run_done_write: got %p want %p", got, exp);
        end
    endtask

    task automatic test_idle_drop();
        logic [7:0] got[$];
        int se, fl, cyc;
        wr_en = 1'b1; wr_addr = 32'd10; wr_data = 8'h99;
        rd_en = 1'b1; rd_addr = 32'd2; run_done = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_read: got rd_data=%h busy=%b want 00 0", rd_data, busy);
        end
        tick();
        wr_en = 1'b0; rd_en = 1'b0; run_done = 1'b0;
        do_dump(32'd10, 1, 0, got, se, fl, cyc);
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'h07 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_write_dropped: got %p err=%b want '{07} 0", got, err);
        end
    endtask

    task automatic test_len_zero();
        send_cmd(2'd0, 32'd0, 0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_load: got busy=%b cmd_ready=%b ld_ready=%b want 0 1 0",
                     busy, cmd_ready, ld_ready);
        end
        tick();
        send_cmd(2'd2, 32'd0, 0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_dump: got busy=%b dp_valid=%b want 0 0", busy, dp_valid);
        end
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int len = int'($urandom_range(1, 24));
            int base = int'($urandom_range(0, DEPTH - len));
            logic [7:0] w[$];
            logic [7:0] got[$];
            int se, fl, cyc, bad;
            w = {};
            for (int i = 0; i < len; i++) w.push_back(8'($urandom));
            do_load(32'(base), w, 1'b1);
            send_cmd(2'd1, 32'd0, 0);
            tick();
            bad = 0;
            for (int c = 0; c < 40; c++) begin
                logic [7:0] exp_rd;
                int ra, wa;
                ra = base + int'($urandom_range(0, len - 1));
                wa = base + int'($urandom_range(0, len - 1));
                rd_en = 1'($urandom_range(0, 1)); rd_addr = 32'(ra);
                wr_en = 1'($urandom_range(0, 1)); wr_addr = 32'(wa); wr_data = 8'($urandom);
                exp_rd = rd_en ? model[ra] : 8'h00;
                @(negedge clk);
                n_checks++;
                if (rd_data !== exp_rd) begin
                    n_fail++;
                    bad++;
                    if (bad < 4) $display("FAIL rand_run_read: addr=%0d got %h want %h", ra, rd_data, exp_rd);
                end
                tick();
                if (wr_en) model[wa] = wr_data;
            end
            rd_en = 1'b0; wr_en = 1'b0;
            run_done = 1'b1;
            tick();
            run_done = 1'b0;
            do_dump(32'(base), len, 2, got, se, fl, cyc);
            n_checks++;
            if (got.size() != len || se != 0) begin
                n_fail++;
                $display("FAIL rand_dump_shape: got size=%0d stall_err=%0d want %0d 0", got.size(), se, len);
            end
            for (int i = 0; i < got.size(); i++) begin
                n_checks++;
                if (got[i] !== model[base + i]) begin
                    n_fail++;
                    $display("FAIL rand_dump_word: idx=%0d got %h want %h", i, got[i], model[base + i]);
                end
            end
        end
    endtask

    task automatic test_range_err();
        logic [7:0] w[$] = '{8'hAA, 8'hBB};
        logic [7:0] got[$];
        int se, fl, cyc;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before_range: got %b want 0", err);
        end
        send_cmd(2'd1, 32'd0, 0);
        tick();
        rd_en = 1'b1; rd_addr = 32'(DEPTH);
        @(negedge clk);
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL range_read: got %h want 00", rd_data);
        end
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_err_set: got %b want 1", err);
        end
        run_done = 1'b1;
        tick();
        run_done = 1'b0;
        // base+1 wraps to address 0.
        do_load(32'hFFFF_FFFF, w, 1'b0);
        do_dump(32'd0, 1, 0, got, se, fl, cyc);
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'hBB) begin
            n_fail++;
            $display("FAIL wrap_load: got %p want '{bb}", got);
        end
        do_dump(32'(DEPTH - 1), 2, 0, got, se, fl, cyc);
        n_checks++;
        if (got.size() != 2 || got[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL range_dump: got %p want 2 words, last 00", got);
        end
        send_cmd(2'd3, 32'd0, 0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL rsvd_and_sticky: got busy=%b err=%b want 0 1", busy, err);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] got[$];
        logic [7:0] exp[$] = '{8'h21, 8'h22};
        int se, fl, cyc;
        send_cmd(2'd0, 32'd200, 4);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = exp[i];
            tick();
            model[200 + i] = exp[i];
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ld_ready !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: got busy=%b ld_ready=%b cmd_ready=%b err=%b want 0 0 1 0",
                     busy, ld_ready, cmd_ready, err);
        end
        tick();
        rst = 1'b0;
        tick();
        do_dump(32'd200, 2, 0, got, se, fl, cyc);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL partial_data_kept: got %p want %p", got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_dump();
        test_dump_stall();
        test_run();
        test_same_cycle();
        test_idle_drop();
        test_len_zero();
        test_random();
        test_range_err();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
